// File: rtl/snowbro2_sdram_pkg.sv
// Shared definitions for the snowbro2 SDRAM responder: FSM encoding,
// burst length, refresh hold time and a one-hot decode helper.
// The REFRESH state exists only with SNOWBRO2_SDRAM_REFRESH_EN defined.
package snowbro2_sdram_pkg;

  localparam int BURST_LEN    = 2;
  localparam int REFRESH_HOLD = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WRITE  = 3'd1,
    WGUARD = 3'd2,
    RD0    = 3'd3,
    RD1    = 3'd4,
    RWAIT  = 3'd5
`ifdef SNOWBRO2_SDRAM_REFRESH_EN
    , REFRESH = 3'd6
`endif
  } state_t;

  // Index of the set bit in a one-hot 4-bit vector (0 when empty).
  function automatic logic [1:0] onehot_to_idx(input logic [3:0] oh);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (oh[i]) idx = i[1:0];
    end
    return idx;
  endfunction

endpackage

// File: rtl/snowbro2_sdram_resp_if.sv
// Request/grant bundle between the responder FSM and the round-robin
// arbiter. Handshake: req is the level of pending bank requests, grant is
// the one-hot winner for the current cycle, and take is asserted in the
// cycle the FSM accepts that grant; the arbiter pointer moves only then.
interface snowbro2_sdram_resp_if;
  logic [3:0] req;
  logic       take;
  logic [3:0] grant;

  modport master (output req, output take, input grant);
  modport slave  (input req, input take, output grant);
endinterface

// File: rtl/snowbro2_rr_arb4.sv
// Four-way round-robin arbiter: searches upward starting after the last
// granted bank; the pointer resets to bank 3 so bank 0 wins first.
module snowbro2_rr_arb4
  import snowbro2_sdram_pkg::*;
(
  input logic                   clk,
  input logic                   rst,
  snowbro2_sdram_resp_if.slave  arb
);

  logic [1:0] last;

  // Combinational one-hot grant, scanning last+1 .. last+4.
  always_comb begin
    logic [1:0] idx;
    logic       found;
    arb.grant = 4'b0000;
    found     = 1'b0;
    idx       = 2'd0;
    for (int i = 1; i <= 4; i++) begin
      idx = last + i[1:0];
      if (!found && arb.req[idx]) begin
        arb.grant[idx] = 1'b1;
        found          = 1'b1;
      end
    end
  end

  // Pointer follows the accepted grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) last <= 2'd3;
    else if (arb.take) last <= onehot_to_idx(arb.grant);
  end

endmodule

// File: rtl/snowbro2_sdram_resp.sv
// snowbro2 SDRAM responder: one loader write port and four banked burst
// readers (2-word bursts) sharing a single backing memory.
// Optional refresh blackouts: define SNOWBRO2_SDRAM_REFRESH_EN.
module snowbro2_sdram_resp
  import snowbro2_sdram_pkg::*;
#(
  parameter int READ_LAT       = 2,
  parameter int REFRESH_PERIOD = 768
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        DOWNLOADING,
  input  logic [21:0] PROG_ADDR,
  input  logic [15:0] PROG_DATA,
  input  logic [1:0]  PROG_MASK,
  input  logic [1:0]  PROG_BA,
  input  logic        PROG_WE,
  output logic        PROG_RDY,
  input  logic [21:0] BA0_ADDR,
  input  logic [21:0] BA1_ADDR,
  input  logic [21:0] BA2_ADDR,
  input  logic [21:0] BA3_ADDR,
  input  logic [3:0]  BA_RD,
  output logic [3:0]  BA_ACK,
  output logic [3:0]  BA_DST,
  output logic [3:0]  BA_DOK,
  output logic [3:0]  BA_RDY,
  output logic [15:0] DATA_READ,
  output logic [23:0] MEM_ADDR,
  output logic        MEM_RD,
  output logic        MEM_WR,
  output logic [15:0] MEM_WDATA,
  output logic [1:0]  MEM_WMASK,
  input  logic [15:0] MEM_RDATA
);

  if (READ_LAT < 1 || READ_LAT > 4 || REFRESH_PERIOD < 2) begin : g_bad_param
    $error("snowbro2_sdram_resp: parameter out of range");
  end

  state_t state, state_nx;
  logic        grant_fire;
  logic        rd_allowed;
  logic [1:0]  rd_bank;
  logic [21:0] rd_addr;
  logic [3:0]  bank_oh;
  logic [BURST_LEN-1:0] launch;
  logic [BURST_LEN-1:0] tail;
  logic [READ_LAT:0][BURST_LEN-1:0] word_pipe;

  snowbro2_sdram_resp_if arb_bus ();

  assign arb_bus.req  = BA_RD;
  assign arb_bus.take = grant_fire;

  snowbro2_rr_arb4 u_arb (
    .clk (CLK),
    .rst (RESET),
    .arb (arb_bus.slave)
  );

  // A loader write always beats a read while a download is active.
  assign rd_allowed = !(DOWNLOADING && PROG_WE);

`ifdef SNOWBRO2_SDRAM_REFRESH_EN
  localparam int REF_W  = $clog2(REFRESH_PERIOD);
  localparam int HOLD_W = $clog2(REFRESH_HOLD);
  logic [REF_W-1:0]  ref_cnt;
  logic [HOLD_W-1:0] hold_cnt;
  logic              refresh_pend;
  logic              ref_wrap;

  assign ref_wrap = (ref_cnt == REF_W'(REFRESH_PERIOD - 1));

  // Free-running period counter; a single sticky request, never queued.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ref_cnt      <= '0;
      refresh_pend <= 1'b0;
    end else begin
      ref_cnt <= ref_wrap ? '0 : ref_cnt + 1'b1;
      if (ref_wrap) refresh_pend <= 1'b1;
      else if (state == IDLE && state_nx == REFRESH) refresh_pend <= 1'b0;
    end
  end

  // Counts cycles spent in the REFRESH blackout.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) hold_cnt <= '0;
    else if (state == REFRESH) hold_cnt <= hold_cnt + 1'b1;
    else hold_cnt <= '0;
  end
`endif

  // State register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else state <= state_nx;
  end

  // Next-state and memory-side outputs.
  always_comb begin
    state_nx   = state;
    grant_fire = 1'b0;
    MEM_RD     = 1'b0;
    MEM_WR     = 1'b0;
    MEM_ADDR   = 24'h0;
    MEM_WDATA  = 16'h0;
    MEM_WMASK  = 2'b00;
    PROG_RDY   = 1'b0;
    case (state)
      IDLE: begin
`ifdef SNOWBRO2_SDRAM_REFRESH_EN
        if (refresh_pend) state_nx = REFRESH;
        else
`endif
        if (PROG_WE) state_nx = WRITE;
        else if (rd_allowed && (|BA_RD) && !RESET) begin
          grant_fire = 1'b1;
          state_nx   = RD0;
        end
      end
      WRITE: begin
        MEM_WR    = 1'b1;
        MEM_ADDR  = {PROG_BA, PROG_ADDR};
        MEM_WDATA = PROG_DATA;
        MEM_WMASK = PROG_MASK;
        PROG_RDY  = 1'b1;
        state_nx  = WGUARD;
      end
      WGUARD: state_nx = IDLE;
      RD0: begin
        MEM_RD   = 1'b1;
        MEM_ADDR = {rd_bank, rd_addr};
        state_nx = RD1;
      end
      RD1: begin
        MEM_RD   = 1'b1;
        MEM_ADDR = {rd_bank, rd_addr + 22'd1};
        state_nx = RWAIT;
      end
      RWAIT: if (tail[BURST_LEN-1]) state_nx = IDLE;
`ifdef SNOWBRO2_SDRAM_REFRESH_EN
      REFRESH: if (hold_cnt == HOLD_W'(REFRESH_HOLD - 1)) state_nx = IDLE;
`endif
      default: state_nx = IDLE;
    endcase
  end

  // Latch the winning bank and its address on the grant cycle.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      rd_bank <= 2'd0;
      rd_addr <= 22'h0;
    end else if (grant_fire) begin
      rd_bank <= onehot_to_idx(arb_bus.grant);
      case (onehot_to_idx(arb_bus.grant))
        2'd0:    rd_addr <= BA0_ADDR;
        2'd1:    rd_addr <= BA1_ADDR;
        2'd2:    rd_addr <= BA2_ADDR;
        default: rd_addr <= BA3_ADDR;
      endcase
    end
  end

  // Word-tag pipeline: tags leave READ_LAT+1 cycles after RD0/RD1, matching
  // memory latency plus the DATA_READ register.
  assign launch = {state == RD1, state == RD0};
  assign tail   = word_pipe[READ_LAT];

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      word_pipe <= '0;
      DATA_READ <= 16'h0;
    end else begin
      word_pipe <= {word_pipe[READ_LAT-1:0], launch};
      DATA_READ <= MEM_RDATA;
    end
  end

  assign bank_oh = 4'b0001 << rd_bank;
  assign BA_ACK  = grant_fire ? arb_bus.grant : 4'b0000;
  assign BA_DST  = tail[0] ? bank_oh : 4'b0000;
  assign BA_DOK  = (|tail) ? bank_oh : 4'b0000;
  assign BA_RDY  = tail[BURST_LEN-1] ? bank_oh : 4'b0000;

endmodule

// File: tb/tb_snowbro2_sdram_resp.sv
// Directed bench for snowbro2_sdram_resp with a latency-accurate memory
// model whose read data is a fixed function of the address.
module tb_snowbro2_sdram_resp;

  localparam int RL = 2;
  localparam int RP = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        downloading = 1'b0;
  logic [21:0] prog_addr = '0;
  logic [15:0] prog_data = '0;
  logic [1:0]  prog_mask = '0;
  logic [1:0]  prog_ba = '0;
  logic        prog_we = 1'b0;
  logic        prog_rdy;
  logic [21:0] ba0_addr = '0, ba1_addr = '0, ba2_addr = '0, ba3_addr = '0;
  logic [3:0]  ba_rd = '0;
  logic [3:0]  ba_ack, ba_dst, ba_dok, ba_rdy;
  logic [15:0] data_read;
  logic [23:0] mem_addr;
  logic        mem_rd, mem_wr;
  logic [15:0] mem_wdata;
  logic [1:0]  mem_wmask;
  logic [15:0] mem_rdata;
  logic [15:0] mq [RL];

  int n_tests = 0;
  int n_fail  = 0;

  // clock / reset
  always #5 clk = ~clk;

  snowbro2_sdram_resp #(.READ_LAT(RL), .REFRESH_PERIOD(RP)) dut (
    .CLK(clk), .RESET(reset), .DOWNLOADING(downloading),
    .PROG_ADDR(prog_addr), .PROG_DATA(prog_data), .PROG_MASK(prog_mask),
    .PROG_BA(prog_ba), .PROG_WE(prog_we), .PROG_RDY(prog_rdy),
    .BA0_ADDR(ba0_addr), .BA1_ADDR(ba1_addr), .BA2_ADDR(ba2_addr),
    .BA3_ADDR(ba3_addr), .BA_RD(ba_rd), .BA_ACK(ba_ack), .BA_DST(ba_dst),
    .BA_DOK(ba_dok), .BA_RDY(ba_rdy), .DATA_READ(data_read),
    .MEM_ADDR(mem_addr), .MEM_RD(mem_rd), .MEM_WR(mem_wr),
    .MEM_WDATA(mem_wdata), .MEM_WMASK(mem_wmask), .MEM_RDATA(mem_rdata)
  );

  // standalone arbiter instance through the shared interface
  snowbro2_sdram_resp_if tb_arb_bus ();
  snowbro2_rr_arb4 u_arb (.clk(clk), .rst(reset), .arb(tb_arb_bus));
  initial begin
    tb_arb_bus.req  = 4'b0000;
    tb_arb_bus.take = 1'b0;
  end

  function automatic logic [15:0] memf(input logic [23:0] a);
    return a[15:0] ^ {a[23:22], 14'h0};
  endfunction

  // memory model: data appears RL cycles after the MEM_RD cycle
  initial for (int k = 0; k < RL; k++) mq[k] = 16'h0;
  always @(posedge clk) begin
    for (int k = RL - 1; k > 0; k--) mq[k] <= mq[k-1];
    mq[0] <= mem_rd ? memf(mem_addr) : 16'hDEAD;
  end
  assign mem_rdata = mq[RL-1];

  // driver helpers
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    step(); reset = 1'b1;
    step(); step(); reset = 1'b0;
  endtask

  task automatic test_reset();
    ba_rd = 4'b1111;
    @(negedge clk);
    n_tests++; if (ba_ack !== 4'b0) begin n_fail++; $display("FAIL rst_ack got %b want 0000", ba_ack); end
    n_tests++; if ({ba_dst, ba_dok, ba_rdy} !== 12'h0) begin n_fail++; $display("FAIL rst_ba got %h want 000", {ba_dst, ba_dok, ba_rdy}); end
    n_tests++; if ({mem_rd, mem_wr, prog_rdy} !== 3'b0) begin n_fail++; $display("FAIL rst_strobe got %b want 000", {mem_rd, mem_wr, prog_rdy}); end
    n_tests++; if (data_read !== 16'h0) begin n_fail++; $display("FAIL rst_data got %h want 0000", data_read); end
    n_tests++; if (mem_addr !== 24'h0) begin n_fail++; $display("FAIL rst_addr got %h want 000000", mem_addr); end
    ba_rd = 4'b0000;
    step(); reset = 1'b0;
  endtask

  task automatic test_arb();
    step(); tb_arb_bus.req = 4'b1010; #1;
    n_tests++; if (tb_arb_bus.grant !== 4'b0010) begin n_fail++; $display("FAIL arb_first got %b want 0010", tb_arb_bus.grant); end
    tb_arb_bus.take = 1'b1;
    step(); tb_arb_bus.take = 1'b0; #1;
    n_tests++; if (tb_arb_bus.grant !== 4'b1000) begin n_fail++; $display("FAIL arb_next got %b want 1000", tb_arb_bus.grant); end
    tb_arb_bus.req = 4'b0000;
  endtask

  task automatic test_write();
    int wr_cnt;
    wr_cnt = 0;
    step(); prog_we = 1'b1; prog_ba = 2'd1; prog_addr = 22'h000010; prog_data = 16'hA55A; prog_mask = 2'b10;
    @(negedge clk); wr_cnt += int'(mem_wr);
    n_tests++; if ({mem_wr, prog_rdy} !== 2'b00) begin n_fail++; $display("FAIL wr_idle got %b want 00", {mem_wr, prog_rdy}); end
    step(); @(negedge clk); wr_cnt += int'(mem_wr);
    n_tests++; if ({mem_wr, prog_rdy} !== 2'b11) begin n_fail++; $display("FAIL wr_strobe got %b want 11", {mem_wr, prog_rdy}); end
    n_tests++; if (mem_addr !== 24'h400010) begin n_fail++; $display("FAIL wr_addr got %h want 400010", mem_addr); end
    n_tests++; if ({mem_wdata, mem_wmask} !== {16'hA55A, 2'b10}) begin n_fail++; $display("FAIL wr_data got %h/%b want a55a/10", mem_wdata, mem_wmask); end
    step(); @(negedge clk); wr_cnt += int'(mem_wr);
    n_tests++; if ({mem_wr, prog_rdy} !== 2'b00) begin n_fail++; $display("FAIL wr_guard got %b want 00", {mem_wr, prog_rdy}); end
    step(); prog_we = 1'b0;
    for (int i = 0; i < 5; i++) begin @(negedge clk); wr_cnt += int'(mem_wr); step(); end
    n_tests++; if (wr_cnt != 1) begin n_fail++; $display("FAIL wr_count got %0d want 1", wr_cnt); end
  endtask

  task automatic test_read();
    step(); ba1_addr = 22'h3FFFFF; ba_rd = 4'b0010;
    @(negedge clk);
    n_tests++; if (ba_ack !== 4'b0010) begin n_fail++; $display("FAIL rd_ack got %b want 0010", ba_ack); end
    step(); ba_rd = 4'b0000; @(negedge clk);
    n_tests++; if ({mem_rd, mem_addr} !== {1'b1, 24'h7FFFFF}) begin n_fail++; $display("FAIL rd_w0_addr got %b/%h want 1/7fffff", mem_rd, mem_addr); end
    step(); @(negedge clk);
    n_tests++; if ({mem_rd, mem_addr} !== {1'b1, 24'h400000}) begin n_fail++; $display("FAIL rd_w1_wrap got %b/%h want 1/400000", mem_rd, mem_addr); end
    step(); @(negedge clk);
    n_tests++; if ({ba_dst, ba_dok, ba_rdy, mem_rd} !== 13'h0) begin n_fail++; $display("FAIL rd_wait got %h want 0", {ba_dst, ba_dok, ba_rdy, mem_rd}); end
    step(); @(negedge clk);
    n_tests++; if ({ba_dst, ba_dok, ba_rdy} !== 12'h220) begin n_fail++; $display("FAIL rd_word0_flags got %h want 220", {ba_dst, ba_dok, ba_rdy}); end
    n_tests++; if (data_read !== 16'hBFFF) begin n_fail++; $display("FAIL rd_word0_data got %h want bfff", data_read); end
    step(); @(negedge clk);
    n_tests++; if ({ba_dst, ba_dok, ba_rdy} !== 12'h022) begin n_fail++; $display("FAIL rd_word1_flags got %h want 022", {ba_dst, ba_dok, ba_rdy}); end
    n_tests++; if (data_read !== 16'h4000) begin n_fail++; $display("FAIL rd_word1_data got %h want 4000", data_read); end
    step(); @(negedge clk);
    n_tests++; if ({ba_dok, ba_rdy} !== 8'h0) begin n_fail++; $display("FAIL rd_after got %h want 00", {ba_dok, ba_rdy}); end
  endtask

  task automatic test_collision();
    bit got_rdy;
    step();
    downloading = 1'b1; prog_we = 1'b1; prog_ba = 2'd0; prog_addr = 22'h000020;
    prog_data = 16'h1234; prog_mask = 2'b00; ba0_addr = 22'h000100; ba_rd = 4'b0001;
    @(negedge clk);
    n_tests++; if ({ba_ack, mem_wr} !== 5'b0) begin n_fail++; $display("FAIL col_idle got %b want 00000", {ba_ack, mem_wr}); end
    step(); @(negedge clk);
    n_tests++; if ({mem_wr, mem_addr, ba_ack} !== {1'b1, 24'h000020, 4'b0}) begin n_fail++; $display("FAIL col_write got %b/%h/%b want 1/000020/0000", mem_wr, mem_addr, ba_ack); end
    step(); prog_we = 1'b0; @(negedge clk);
    n_tests++; if (ba_ack !== 4'b0) begin n_fail++; $display("FAIL col_guard got %b want 0000", ba_ack); end
    step(); @(negedge clk);
    n_tests++; if (ba_ack !== 4'b0001) begin n_fail++; $display("FAIL col_ack got %b want 0001", ba_ack); end
    step(); ba_rd = 4'b0000; downloading = 1'b0;
    got_rdy = 1'b0;
    for (int i = 0; i < 10 && !got_rdy; i++) begin
      @(negedge clk);
      if (ba_rdy != 4'b0) begin
        got_rdy = 1'b1;
        n_tests++; if ({ba_rdy, data_read} !== {4'b0001, 16'h0101}) begin n_fail++; $display("FAIL col_rdy got %b/%h want 0001/0101", ba_rdy, data_read); end
      end
      step();
    end
    n_tests++; if (!got_rdy) begin n_fail++; $display("FAIL col_timeout got no_rdy want rdy"); end
  endtask

  task automatic test_round_robin();
    int order [5];
    int n_grant, n_rdy, n_multi, rdy_between_bad;
    logic [3:0] exp_oh;
    do_reset();
    ba0_addr = 22'h10; ba1_addr = 22'h20; ba2_addr = 22'h30; ba3_addr = 22'h40;
    ba_rd = 4'b1111;
    n_grant = 0; n_rdy = 0; n_multi = 0; rdy_between_bad = 0;
    for (int c = 0; c < 60 && n_grant < 5; c++) begin
      @(negedge clk);
      if ($countones(ba_ack) > 1 || $countones(ba_rdy) > 1 || $countones(ba_dok) > 1) n_multi++;
      if (ba_rdy != 4'b0) n_rdy++;
      if (ba_ack != 4'b0) begin
        if (n_rdy != n_grant) rdy_between_bad++;
        for (int b = 0; b < 4; b++) if (ba_ack[b]) order[n_grant] = b;
        n_grant++;
      end
      step();
    end
    ba_rd = 4'b0000;
    for (int c = 0; c < 10; c++) begin @(negedge clk); if (ba_rdy != 4'b0) n_rdy++; step(); end
    n_tests++; if (n_grant != 5) begin n_fail++; $display("FAIL rr_grants got %0d want 5", n_grant); end
    for (int g = 0; g < 5 && g < n_grant; g++) begin
      exp_oh = 4'b0001 << (g % 4);
      n_tests++; if (order[g] != g % 4) begin n_fail++; $display("FAIL rr_order[%0d] got %0d want %0d (%b)", g, order[g], g % 4, exp_oh); end
    end
    n_tests++; if (n_rdy != 5 || rdy_between_bad != 0) begin n_fail++; $display("FAIL rr_rdy got %0d/%0d want 5/0", n_rdy, rdy_between_bad); end
    n_tests++; if (n_multi != 0) begin n_fail++; $display("FAIL rr_onehot got %0d want 0", n_multi); end
  endtask

  task automatic test_mid_reset();
    int bad;
    step(); ba2_addr = 22'h000123; ba_rd = 4'b0100;
    @(negedge clk);
    n_tests++; if (ba_ack !== 4'b0100) begin n_fail++; $display("FAIL mr_ack got %b want 0100", ba_ack); end
    step(); ba_rd = 4'b0000;
    step(); reset = 1'b1; #1;
    n_tests++; if ({mem_rd, mem_wr, prog_rdy, mem_addr} !== 27'h0) begin n_fail++; $display("FAIL mr_mem got %b/%h want 0/000000", mem_rd, mem_addr); end
    n_tests++; if ({ba_ack, ba_dst, ba_dok, ba_rdy, data_read} !== 32'h0) begin n_fail++; $display("FAIL mr_ba got %h want 0", {ba_ack, ba_dst, ba_dok, ba_rdy, data_read}); end
    step(); step(); reset = 1'b0;
    bad = 0;
    for (int c = 0; c < 8; c++) begin @(negedge clk); if ({ba_dok, ba_rdy, mem_rd} != 9'h0) bad++; step(); end
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL mr_dropped got %0d want 0", bad); end
    ba2_addr = 22'h000200; ba_rd = 4'b0100;
    @(negedge clk);
    n_tests++; if (ba_ack !== 4'b0100) begin n_fail++; $display("FAIL mr_reack got %b want 0100", ba_ack); end
    step(); ba_rd = 4'b0000; @(negedge clk);
    n_tests++; if ({mem_rd, mem_addr} !== {1'b1, 24'h800200}) begin n_fail++; $display("FAIL mr_w0 got %b/%h want 1/800200", mem_rd, mem_addr); end
    step(); @(negedge clk);
    n_tests++; if ({mem_rd, mem_addr} !== {1'b1, 24'h800201}) begin n_fail++; $display("FAIL mr_w1 got %b/%h want 1/800201", mem_rd, mem_addr); end
    step(); step(); @(negedge clk);
    n_tests++; if ({ba_dst, ba_dok, ba_rdy, data_read} !== {12'h440, 16'h8200}) begin n_fail++; $display("FAIL mr_word0 got %h/%h want 440/8200", {ba_dst, ba_dok, ba_rdy}, data_read); end
    step(); @(negedge clk);
    n_tests++; if ({ba_dst, ba_dok, ba_rdy, data_read} !== {12'h044, 16'h8201}) begin n_fail++; $display("FAIL mr_word1 got %h/%h want 044/8201", {ba_dst, ba_dok, ba_rdy}, data_read); end
    step();
  endtask

`ifdef SNOWBRO2_SDRAM_REFRESH_EN
  task automatic test_refresh();
    int gap, n_ref, n_bad_gap, n_ack, n_rdy;
    bit seen_rd;
    do_reset();
    ba0_addr = 22'h000000; ba_rd = 4'b0001;
    gap = 0; n_ref = 0; n_bad_gap = 0; n_ack = 0; n_rdy = 0; seen_rd = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (ba_ack != 4'b0) n_ack++;
      if (ba_rdy != 4'b0) n_rdy++;
      if (mem_rd) begin
        if (seen_rd && gap == 9) n_ref++;
        else if (seen_rd && gap != 0 && gap != 4) n_bad_gap++;
        seen_rd = 1'b1; gap = 0;
      end else gap++;
      step();
    end
    ba_rd = 4'b0000;
    for (int c = 0; c < 12; c++) begin @(negedge clk); if (ba_rdy != 4'b0) n_rdy++; step(); end
    n_tests++; if (n_ref < 9 || n_ref > 13) begin n_fail++; $display("FAIL ref_gaps got %0d want 9..13", n_ref); end
    n_tests++; if (n_bad_gap != 0) begin n_fail++; $display("FAIL ref_bad_gap got %0d want 0", n_bad_gap); end
    n_tests++; if (n_ack != n_rdy || n_ack == 0) begin n_fail++; $display("FAIL ref_rdy got %0d want %0d", n_rdy, n_ack); end
  endtask
`endif

  initial begin
    test_reset();
    test_arb();
    test_write();
    test_read();
    test_collision();
    test_round_robin();
    test_mid_reset();
`ifdef SNOWBRO2_SDRAM_REFRESH_EN
    test_refresh();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
